// File: rtl/tqvp_byte_capture.sv
// tqvp_byte_capture: TinyQV peripheral that samples ui_in every DIV+1 clocks
// into a small FIFO which the CPU drains via the register interface.
// Optional macro CAPTURE_AVG_EN adds a 4-sample averaging mode (CTRL bit2).
module tqvp_byte_capture #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [7:0]    sync1_q, sync2_q;
  logic          en_q, en_d;
  logic [7:0]    div_q, div_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [7:0]    uo_q, uo_d;
  logic [7:0]    mem_q [0:DEPTH-1];

  logic ctrl_wr_s, div_wr_s, stat_wr_s, pop_req_s, flush_s, tick_s;
  logic full_s, empty_s, do_push_s, do_pop_s, wr_en_s;
  logic push_s, avg_rd_s;
  logic [7:0] push_data_s;
  logic [7:0] count8_s;

  assign ctrl_wr_s = data_write && (address == 4'h0);
  assign div_wr_s  = data_write && (address == 4'h1);
  assign stat_wr_s = data_write && (address == 4'h2);
  assign pop_req_s = data_write && (address == 4'h3);
  assign flush_s   = ctrl_wr_s && data_in[1];
  assign tick_s    = en_q && (cnt_q == div_q);
  assign full_s    = (count_q == CNT_FULL);
  assign empty_s   = (count_q == {CW{1'b0}});
  assign count8_s  = {{(8-CW){1'b0}}, count_q};
  assign uo_out    = uo_q;

  // Control registers and tick counter next state; any CTRL/DIV write restarts the period
  always_comb begin
    en_d  = ctrl_wr_s ? data_in[0] : en_q;
    div_d = div_wr_s ? data_in : div_q;
    if (ctrl_wr_s || div_wr_s) begin
      cnt_d = 8'h00;
    end else if (!en_q || tick_s) begin
      cnt_d = 8'h00;
    end else begin
      cnt_d = cnt_q + 8'h01;
    end
  end

`ifdef CAPTURE_AVG_EN
  logic       avg_q, avg_d;
  logic [9:0] acc_q, acc_d, acc_sum_s;
  logic [1:0] phase_q, phase_d;
  logic       avg_clr_s;

  assign avg_rd_s = avg_q;

  // Averaging path: raw push when AVG=0, otherwise push the mean of every 4 ticks
  always_comb begin
    avg_d       = ctrl_wr_s ? data_in[2] : avg_q;
    avg_clr_s   = !en_q || flush_s || (ctrl_wr_s && (data_in[2] != avg_q));
    acc_sum_s   = acc_q + {2'b00, sync2_q};
    acc_d       = acc_q;
    phase_d     = phase_q;
    push_s      = 1'b0;
    push_data_s = sync2_q;
    if (!avg_q) begin
      push_s  = tick_s;
      acc_d   = 10'd0;
      phase_d = 2'd0;
    end else if (avg_clr_s) begin
      acc_d   = 10'd0;
      phase_d = 2'd0;
    end else if (tick_s) begin
      if (phase_q == 2'd3) begin
        push_s      = 1'b1;
        push_data_s = acc_sum_s[9:2];
        acc_d       = 10'd0;
        phase_d     = 2'd0;
      end else begin
        acc_d   = acc_sum_s;
        phase_d = phase_q + 2'd1;
      end
    end else begin
      acc_d   = acc_q;
      phase_d = phase_q;
    end
  end

  // Averaging state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_q   <= 1'b0;
      acc_q   <= 10'd0;
      phase_q <= 2'd0;
    end else begin
      avg_q   <= avg_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end
`else
  assign avg_rd_s    = 1'b0;
  assign push_s      = tick_s;
  assign push_data_s = sync2_q;
`endif

  // FIFO bookkeeping: flush dominates, full+pop still accepts the push, empty+push ignores the pop
  always_comb begin
    do_pop_s  = pop_req_s && !empty_s;
    do_push_s = push_s && (!full_s || pop_req_s);
    wr_en_s   = do_push_s && !flush_s;
    uo_d      = push_s ? push_data_s : uo_q;
    if (flush_s) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      rd_ptr_d = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      ovf_d = (ovf_q && !(stat_wr_s && data_in[6])) || (push_s && full_s && !pop_req_s);
      unf_d = (unf_q && !(stat_wr_s && data_in[7])) || (pop_req_s && empty_s && !push_s);
    end
  end

  // State registers, synchronizer and FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      en_q     <= 1'b0;
      div_q    <= 8'h00;
      cnt_q    <= 8'h00;
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      uo_q     <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      sync1_q  <= ui_in;
      sync2_q  <= sync1_q;
      en_q     <= en_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      uo_q     <= uo_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= push_data_s;
      end
    end
  end

  // Zero-latency register read mux
  always_comb begin
    case (address)
      4'h0:    data_out = {5'b00000, avg_rd_s, 1'b0, en_q};
      4'h1:    data_out = div_q;
      4'h2:    data_out = {unf_q, ovf_q, full_s, empty_s, count8_s[3:0]};
      4'h3:    data_out = empty_s ? 8'h00 : mem_q[rd_ptr_q];
      4'h4:    data_out = sync2_q;
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_byte_capture.sv
// Scoreboard bench for tqvp_byte_capture: the driver predicts every read from a
// queue-based reference model and pushes it; a negedge monitor pops and compares.
module tb_tqvp_byte_capture;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in, uo_out, data_in, data_out;
  logic [3:0] address;
  logic       data_write;

  tqvp_byte_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] exp_d;
    logic [7:0] exp_uo;
  } exp_t;
  exp_t sb[$];
  logic chk_v = 1'b0;

  // reference model state
  bit         m_en, m_avg, m_ovf, m_unf;
  logic [7:0] m_div, m_uo, m_s1, m_s2;
  int         m_elapsed;
  logic [7:0] m_fifo[$];
  int         m_acc[$];
  logic [7:0] cur_ui;

  function automatic void m_reset();
    m_en = 0; m_avg = 0; m_ovf = 0; m_unf = 0;
    m_div = 8'h00; m_uo = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
    m_elapsed = 0;
    m_fifo.delete();
    m_acc.delete();
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    logic [3:0] sz;
    sz = 4'(m_fifo.size());
    case (a)
      4'h0: return {5'b00000, m_avg, 1'b0, m_en};
      4'h1: return m_div;
      4'h2: return {m_unf, m_ovf, m_fifo.size() == DEPTH, m_fifo.size() == 0, sz};
      4'h3: return (m_fifo.size() == 0) ? 8'h00 : m_fifo[0];
      4'h4: return m_s2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void m_step(input logic wr, input logic [3:0] a, input logic [7:0] d,
                                 input logic [7:0] ui);
    bit tick, pop, flush, push, full, empty;
    logic [7:0] val;
    int s;
    tick  = m_en && ((m_elapsed % (int'(m_div) + 1)) == int'(m_div));
    pop   = wr && (a == 4'h3);
    flush = wr && (a == 4'h0) && d[1];
    push  = 0;
    val   = m_s2;
    if (!m_avg) begin
      push = tick;
      m_acc.delete();
    end else if (!m_en || flush || (wr && (a == 4'h0) && (d[2] != m_avg))) begin
      m_acc.delete();
    end else if (tick) begin
      m_acc.push_back(int'(m_s2));
      if (m_acc.size() == 4) begin
        s = 0;
        foreach (m_acc[i]) s += m_acc[i];
        val  = 8'(s / 4);
        push = 1;
        m_acc.delete();
      end
    end
    if (push) m_uo = val;
    full  = (m_fifo.size() == DEPTH);
    empty = (m_fifo.size() == 0);
    if (flush) begin
      m_fifo.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (wr && (a == 4'h2) && d[6]) m_ovf = 0;
      if (wr && (a == 4'h2) && d[7]) m_unf = 0;
      if (pop && !empty) void'(m_fifo.pop_front());
      if (push) begin
        if (full && !pop) m_ovf = 1;
        else m_fifo.push_back(val);
      end
      if (pop && empty && !push) m_unf = 1;
    end
    if (wr && ((a == 4'h0) || (a == 4'h1))) m_elapsed = 0;
    else if (m_en) m_elapsed++;
    else m_elapsed = 0;
    if (wr && (a == 4'h0)) begin
      m_en = d[0];
`ifdef CAPTURE_AVG_EN
      m_avg = d[2];
`endif
    end
    if (wr && (a == 4'h1)) m_div = d;
    m_s2 = m_s1;
    m_s1 = ui;
  endfunction

  // one clock: drive inputs, predict the observed read, advance the model
  task automatic cyc(input logic wr, input logic [3:0] a, input logic [7:0] d, input string name);
    exp_t e;
    ui_in = cur_ui; address = a; data_write = wr; data_in = d; chk_v = 1'b1;
    e.name = name; e.exp_d = m_read(a); e.exp_uo = m_uo;
    sb.push_back(e);
    if (!rst) m_step(wr, a, d, cur_ui);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input string name);
    cyc(1'b0, a, 8'h00, name);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input string name);
    cyc(1'b1, a, d, name);
  endtask

  // monitor: compare read data and uo_out against the oldest prediction
  always @(negedge clk) begin
    if (chk_v) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_empty: DUT read with no prediction queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 2;
        if (data_out !== e.exp_d) begin
          errors++;
          $display("FAIL %s data_out: got %02h expected %02h (t=%0t)", e.name, data_out, e.exp_d, $time);
        end
        if (uo_out !== e.exp_uo) begin
          errors++;
          $display("FAIL %s uo_out: got %02h expected %02h (t=%0t)", e.name, uo_out, e.exp_uo, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    cur_ui = 8'hA5;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state of every register (RAW sees ui_in after the synchronizer fills)
    for (int a = 0; a < 6; a++) rd(4'(a), "reset_read");

    // DIV=3: one capture every 4 clocks of a held value
    cur_ui = 8'h5A;
    wr(4'h1, 8'h03, "div3_wr");
    wr(4'h0, 8'h01, "div3_en");
    for (int i = 0; i < 14; i++) rd((i % 2 == 0) ? 4'h2 : 4'h3, "div3_run");

    // DIV=0 with counting input: fills, overflows, then drain
    wr(4'h1, 8'h00, "cnt_div0");
    wr(4'h0, 8'h03, "cnt_flush_en");
    for (int i = 0; i < 12; i++) begin
      cur_ui = 8'(i);
      rd(4'h2, "cnt_fill");
    end
    wr(4'h0, 8'h00, "cnt_disable");
    rd(4'h2, "cnt_status");
    for (int i = 0; i < 9; i++) begin
      rd(4'h3, "cnt_head");
      wr(4'h3, 8'h00, "cnt_pop");
    end
    rd(4'h2, "cnt_drained");

    // full FIFO with pops coinciding with ticks
    wr(4'h0, 8'h03, "full_flush_en");
    for (int i = 0; i < 10; i++) begin
      cur_ui = 8'h30 + 8'(i);
      rd(4'h2, "full_fill");
    end
    for (int i = 0; i < 4; i++) begin
      cur_ui = 8'h80 + 8'(i);
      wr(4'h3, 8'h00, "full_pop_tick");
      rd(4'h2, "full_status");
    end
    wr(4'h0, 8'h00, "full_disable");
    for (int i = 0; i < 9; i++) begin
      rd(4'h3, "full_head");
      wr(4'h3, 8'h00, "full_drain");
    end

    // underflow, sticky clear, flush while capturing
    wr(4'h0, 8'h02, "unf_flush");
    wr(4'h3, 8'h00, "unf_pop_empty");
    rd(4'h2, "unf_status");
    wr(4'h2, 8'h80, "unf_clear");
    rd(4'h2, "unf_cleared");
    wr(4'h1, 8'h01, "fl_div1");
    wr(4'h0, 8'h01, "fl_en");
    for (int i = 0; i < 10; i++) begin
      cur_ui = 8'hC0 + 8'(i);
      rd(4'h2, "fl_fill");
    end
    wr(4'h0, 8'h03, "fl_flush");
    for (int i = 0; i < 6; i++) rd((i % 2 == 0) ? 4'h2 : 4'h3, "fl_after");

    // averaging mode (or AVG bit ignored without the macro)
    wr(4'h1, 8'h00, "avg_div0");
    wr(4'h0, 8'h02, "avg_flush");
    wr(4'h0, 8'h05, "avg_on");
    rd(4'h0, "avg_ctrl");
    cur_ui = 8'd10; rd(4'h2, "avg_s0");
    cur_ui = 8'd20; rd(4'h2, "avg_s1");
    cur_ui = 8'd30; rd(4'h2, "avg_s2");
    cur_ui = 8'd41; rd(4'h2, "avg_s3");
    for (int i = 0; i < 6; i++) rd((i % 2 == 0) ? 4'h2 : 4'h3, "avg_out");
    wr(4'h0, 8'h00, "avg_off");

    // asynchronous reset in the middle of capture
    wr(4'h0, 8'h01, "rst_en");
    for (int i = 0; i < 5; i++) begin
      cur_ui = 8'h11 * 8'(i + 1);
      rd(4'h2, "rst_fill");
    end
    rst = 1'b1;
    m_reset();
    rd(4'h2, "rst_held_status");
    rd(4'h3, "rst_held_data");
    rst = 1'b0;
    for (int a = 0; a < 5; a++) rd(4'(a), "rst_after");

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      cur_ui = 8'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 8) wr(4'h0, {5'b00000, 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)}, "rnd_ctrl");
      else if (r < 14) wr(4'h1, 8'($urandom_range(0, 4)), "rnd_div");
      else if (r < 32) wr(4'h3, 8'($urandom), "rnd_pop");
      else if (r < 36) wr(4'h2, 8'($urandom), "rnd_stat");
      else if (r < 38) wr(4'($urandom_range(4, 15)), 8'($urandom), "rnd_other_wr");
      else rd(4'($urandom_range(0, 15)), "rnd_read");
    end

    chk_v = 1'b0;
    data_write = 1'b0;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: %0d predictions never compared, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tqvp_byte_capture.md
Name: tqvp_byte_capture

Overview:
- TinyQV user peripheral: periodically samples the 8-bit `ui_in` PMOD bus and pushes each sample into a FIFO.
- The CPU drains the FIFO through the register interface.
- Inverse direction of the team's CPU-fed byte FIR peripheral: here the samples come from the pins and the CPU is the consumer.
- `uo_out` mirrors the most recently captured sample, for scope or debug.

Parameters:
- DEPTH, 8, FIFO entries; power of two, range 2..16.
- CW, $clog2(DEPTH)+1, occupancy count width, derived from DEPTH; must not be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  one clock; reset is asynchronous and active-high.
- ui_in  in  8  external sample bus.
- uo_out  out  8  last captured sample.
- address  in  4  local register address.
- data_write  in  1  write strobe, one cycle.
- data_in  in  8  write data.
- data_out  out  8  combinational read data.

Behaviour:
- Register map:
  - 0x0 CTRL: bit0 EN; bit1 FLUSH, self-clearing and always reads 0; bit2 AVG (present only with the macro, otherwise reads 0).
  - 0x1 DIV: sample period is DIV+1 clocks; range 0..255.
  - 0x2 STATUS (read): [3:0] count, bit4 empty, bit5 full, bit6 OVF sticky, bit7 UNF sticky.
  - 0x2 STATUS (write): a 1 in bit6 or bit7 clears that flag.
  - 0x3 DATA: read returns the FIFO head without popping, or 0x00 when empty. Any write pops.
  - 0x4 RAW: synchronized `ui_in`.
  - Other addresses read 0x00.
- Reset (rst=1, asynchronous): CTRL=0, DIV=0, FIFO empty (rd_ptr=wr_ptr=count=0), OVF=UNF=0, tick counter=0, synchronizer=0, `uo_out`=0x00.
- Input path: 2-flop synchronizer on `ui_in`. A captured sample equals `ui_in` as it was 2 cycles before the tick.
- Tick counter:
  - EN=0: counter held at 0, no ticks.
  - EN=1: counter increments each cycle. When counter==DIV, a tick is asserted that cycle and the counter returns to 0.
  - DIV=0 gives a tick every cycle.
  - First tick occurs DIV+1 cycles after the EN write commits.
  - Writing DIV or CTRL resets the counter to 0.
- Push on tick:
  - Sample is written at wr_ptr; wr_ptr wraps modulo DEPTH; count increments.
  - `uo_out` updates to the sample on every tick, even when the push is dropped.
- Pop (write to 0x3): rd_ptr advances modulo DEPTH; count decrements.
- Same-cycle rules:
  - Push+pop, not empty: both occur, count unchanged. This includes full, where the push is accepted.
  - Push+pop while empty: push only; UNF is not set.
  - Push while full with no pop: sample dropped, OVF set, FIFO contents unchanged.
  - Pop while empty with no push: ignored, UNF set.
- FLUSH (write CTRL with bit1=1):
  - Next cycle: count=0, pointers=0, OVF=UNF=0.
  - Takes priority over any push in the same cycle.
  - The EN and AVG bits from the same write take effect normally.
- `data_out` is purely combinational from address and registers; zero-latency read.
- Count saturates at DEPTH by construction. full = (count==DEPTH); empty = (count==0).
- Reset asserted mid-capture discards all FIFO contents immediately.

Optional Feature:
- Macro: CAPTURE_AVG_EN.
- Defined:
  - CTRL bit2 AVG is implemented.
  - With AVG=1, each tick adds the synchronized sample to a 10-bit accumulator. Every 4th tick pushes acc[9:2] (truncating mean) and clears the accumulator.
  - `uo_out` updates only on pushes.
  - Accumulator and phase counter clear on reset, on FLUSH, on EN=0 and on any AVG change.
- Not defined: bit2 is not stored and reads 0; every tick pushes the raw sample.

Test Plan:
- Reset, then read 0x0–0x4 -> 0x00, 0x00, 0x10 (empty), 0x00, synchronized ui_in; `uo_out`=0x00.
- DIV=3, EN=1, ui_in=0x5A held -> push every 4 clocks. After 3 ticks STATUS=0x03, DATA reads 0x5A, `uo_out`=0x5A.
- DIV=0, EN=1 for 12 cycles, ui_in counting 0x00,0x01,… -> STATUS=0x68 (count 8, full, OVF). Pops return 8 consecutive values starting at the first captured value, then STATUS=0x50 (empty, OVF).
- Full FIFO with a pop coinciding with a tick -> count stays 8, OVF not set, new sample appears as the last entry.
- Pop on empty -> UNF set (STATUS=0x90). Write STATUS 0x80 -> STATUS=0x10. Write CTRL=0x03 while holding 5 entries -> STATUS=0x10 next cycle, capture continues.
- With CAPTURE_AVG_EN: AVG=1, DIV=0, samples 10,20,30,41 -> one push of 0x19 (25). Without the macro: CTRL write 0x05 reads back 0x01.
